// File: rtl/control_pkg.sv
// Shared encodings and the control bundle carried through the ID/EX register
// of the pipelined RV32IM control path.
package control_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] RWS_MEM = 2'b00;
    localparam logic [1:0] RWS_ALU = 2'b01;
    localparam logic [1:0] RWS_PC4 = 2'b11;

    localparam logic [3:0] BR_JUMP = 4'b1010;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00010;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SLT  = 5'b01000;
    localparam logic [4:0] ALU_SLTU = 5'b01100;
    localparam logic [4:0] ALU_XOR  = 5'b10000;
    localparam logic [4:0] ALU_SRL  = 5'b10100;
    localparam logic [4:0] ALU_SRA  = 5'b10110;
    localparam logic [4:0] ALU_OR   = 5'b11000;
    localparam logic [4:0] ALU_AND  = 5'b11100;
    localparam logic [4:0] ALU_LUI  = 5'b11111;

    typedef struct packed {
        logic       op1_sel;
        logic       op2_sel;
        logic       reg_write_en;
        logic [2:0] imm_sel;
        logic [3:0] br_sel;
        logic [4:0] alu_op;
        logic [2:0] mem_write;
        logic [3:0] mem_read;
        logic [1:0] reg_write_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

    // alt selects SUB (funct3 000) or SRA (funct3 101)
    function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt);
        unique case (f3)
            3'b000:  base_alu = alt ? ALU_SUB : ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = alt ? ALU_SRA : ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    function automatic logic [4:0] m_alu(input logic [2:0] f3);
        unique case (f3)
            3'b000:  m_alu = 5'b00001;
            3'b001:  m_alu = 5'b00101;
            3'b010:  m_alu = 5'b01101;
            3'b011:  m_alu = 5'b01001;
            3'b100:  m_alu = 5'b10001;
            3'b101:  m_alu = 5'b10101;
            3'b110:  m_alu = 5'b11001;
            default: m_alu = 5'b11101;
        endcase
    endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational RV32IM decode into a control bundle, with illegal-instruction
// detection; illegal encodings yield the NOP bundle.
module control_decoder
    import control_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit M_EXT = 1'b1
) (
    input  logic [WIDTH-1:0] instruction,
    output ctrl_t            ctrl,
    output logic             illegal,
    output logic             m_op
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_bits;

    assign opcode      = instruction[6:0];
    assign funct3      = instruction[14:12];
    assign funct7      = instruction[31:25];
    assign unused_bits = ^instruction;

    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        m_op    = 1'b0;
        unique case (opcode)
            OPC_LUI: begin
                ctrl.imm_sel       = IMM_U;
                ctrl.op2_sel       = 1'b1;
                ctrl.alu_op        = ALU_LUI;
                ctrl.reg_write_en  = 1'b1;
                ctrl.reg_write_sel = RWS_ALU;
            end
            OPC_AUIPC: begin
                ctrl.imm_sel       = IMM_U;
                ctrl.op1_sel       = 1'b1;
                ctrl.op2_sel       = 1'b1;
                ctrl.reg_write_en  = 1'b1;
                ctrl.reg_write_sel = RWS_ALU;
            end
            OPC_JAL: begin
                ctrl.imm_sel       = IMM_J;
                ctrl.op1_sel       = 1'b1;
                ctrl.op2_sel       = 1'b1;
                ctrl.br_sel        = BR_JUMP;
                ctrl.reg_write_en  = 1'b1;
                ctrl.reg_write_sel = RWS_PC4;
            end
            OPC_JALR: begin
                illegal            = (funct3 != 3'b000);
                ctrl.imm_sel       = IMM_I;
                ctrl.op2_sel       = 1'b1;
                ctrl.br_sel        = BR_JUMP;
                ctrl.reg_write_en  = 1'b1;
                ctrl.reg_write_sel = RWS_PC4;
            end
            OPC_BRANCH: begin
                illegal      = (funct3 inside {3'b010, 3'b011});
                ctrl.imm_sel = IMM_B;
                ctrl.op1_sel = 1'b1;
                ctrl.op2_sel = 1'b1;
                ctrl.alu_op  = ALU_SUB;
                ctrl.br_sel  = {1'b1, funct3};
            end
            OPC_LOAD: begin
                illegal            = (funct3 inside {3'b011, 3'b110, 3'b111});
                ctrl.imm_sel       = IMM_I;
                ctrl.op2_sel       = 1'b1;
                ctrl.mem_read      = {1'b1, funct3};
                ctrl.reg_write_en  = 1'b1;
                ctrl.reg_write_sel = RWS_MEM;
            end
            OPC_STORE: begin
                illegal        = (funct3 >= 3'b011);
                ctrl.imm_sel   = IMM_S;
                ctrl.op2_sel   = 1'b1;
                ctrl.mem_write = {1'b1, funct3[1:0]};
            end
            OPC_OPIMM: begin
                // funct7 is immediate data except on SRAI
                ctrl.imm_sel       = IMM_I;
                ctrl.op2_sel       = 1'b1;
                ctrl.alu_op        = base_alu(funct3, funct3 == 3'b101 && funct7[5]);
                ctrl.reg_write_en  = 1'b1;
                ctrl.reg_write_sel = RWS_ALU;
            end
            OPC_OP: begin
                ctrl.reg_write_en  = 1'b1;
                ctrl.reg_write_sel = RWS_ALU;
                unique case (funct7)
                    7'b0000000: ctrl.alu_op = base_alu(funct3, 1'b0);
                    7'b0100000: begin
                        illegal     = !(funct3 inside {3'b000, 3'b101});
                        ctrl.alu_op = base_alu(funct3, 1'b1);
                    end
                    7'b0000001: begin
                        illegal     = !M_EXT;
                        m_op        = M_EXT;
                        ctrl.alu_op = m_alu(funct3);
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            ctrl = CTRL_NOP;
            m_op = 1'b0;
        end
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// ID/EX control register with bubble/flush handling and a MUL/DIV occupancy
// sequencer that holds EX and stalls the front end.
module pipelined_control_unit
    import control_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter bit M_EXT       = 1'b1,
    parameter int MUL_LATENCY = 3,
    parameter int DIV_LATENCY = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] INSTRUCTION,
    input  logic             INSTR_VALID,
    input  logic             STALL_IN,
    input  logic             FLUSH,
    output logic             EX_VALID,
    output logic             EX_ILLEGAL,
    output logic             EX_OP1_SEL,
    output logic             EX_OP2_SEL,
    output logic             EX_REG_WRITE_EN,
    output logic [2:0]       EX_IMM_SEL,
    output logic [3:0]       EX_BR_SEL,
    output logic [4:0]       EX_ALU_OP,
    output logic [2:0]       EX_MEM_WRITE,
    output logic [3:0]       EX_MEM_READ,
    output logic [1:0]       EX_REG_WRITE_SEL,
    output logic             MD_START,
    output logic             MD_STALL
);

    localparam logic [3:0] MUL_LAT = 4'(MUL_LATENCY);
    localparam logic [3:0] DIV_LAT = 4'(DIV_LATENCY);

    ctrl_t      dec_ctrl, ex_q, ex_d;
    logic       dec_illegal, dec_m_op;
    logic       valid_q, valid_d, illegal_q, illegal_d;
    logic       start_q, start_d, stall_q, stall_d;
    md_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d, lat;

    control_decoder #(.WIDTH(WIDTH), .M_EXT(M_EXT)) u_dec (
        .instruction (INSTRUCTION),
        .ctrl        (dec_ctrl),
        .illegal     (dec_illegal),
        .m_op        (dec_m_op)
    );

    assign lat = INSTRUCTION[14] ? DIV_LAT : MUL_LAT;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ex_q      <= CTRL_NOP;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            start_q   <= 1'b0;
            stall_q   <= 1'b0;
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
        end else begin
            ex_q      <= ex_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            start_q   <= start_d;
            stall_q   <= stall_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        ex_d      = ex_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        // stall trails BUSY by one cycle so it rises after the MD_START pulse
        stall_d   = (state_q == MD_BUSY) && !FLUSH;
        if (FLUSH) begin
            ex_d      = CTRL_NOP;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
            state_d   = MD_IDLE;
            cnt_d     = '0;
        end else if (state_q == MD_BUSY) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = MD_IDLE;
        end else if (STALL_IN || !INSTR_VALID) begin
            ex_d      = CTRL_NOP;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else begin
            ex_d      = dec_ctrl;
            valid_d   = 1'b1;
            illegal_d = dec_illegal;
            if (dec_m_op) begin
                start_d = 1'b1;
                if (lat > 4'd1) begin
                    state_d = MD_BUSY;
                    cnt_d   = lat - 4'd1;
                end
            end
        end
    end

    assign EX_VALID         = valid_q;
    assign EX_ILLEGAL       = illegal_q;
    assign EX_OP1_SEL       = ex_q.op1_sel;
    assign EX_OP2_SEL       = ex_q.op2_sel;
    assign EX_REG_WRITE_EN  = ex_q.reg_write_en;
    assign EX_IMM_SEL       = ex_q.imm_sel;
    assign EX_BR_SEL        = ex_q.br_sel;
    assign EX_ALU_OP        = ex_q.alu_op;
    assign EX_MEM_WRITE     = ex_q.mem_write;
    assign EX_MEM_READ      = ex_q.mem_read;
    assign EX_REG_WRITE_SEL = ex_q.reg_write_sel;
    assign MD_START         = start_q;
    assign MD_STALL         = stall_q;

endmodule
